nes_mem_arbiter: RTL
====================

# nes_mem_arbiter

Arbiter sharing the CPU's single memory port between the instruction-fetch unit and the load/store unit (LSU). Each cycle it grants the port to at most one requester and drives the memory address, write-enable and write data. It routes each one-cycle-latency read response back to the requester that issued the read. LSU has priority, with two exceptions: a starvation guard that guarantees fetch progress, and a lock for read-modify-write instructions. The block sits between the fetch state machine / LSU and the memory bus.

## Interface
Parameters:
- MEM_ADDR_SIZE, 16, address width; shared package constant.
- STARVE_LIMIT, 4, consecutive LSU grants tolerated while fetch waits; legal range 1..7.

Ports (name, direction, width, meaning):
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- fetch_req_i  in  1  fetch requests a read.
- fetch_addr_i  in  MEM_ADDR_SIZE  fetch read address.
- fetch_gnt_o  out  1  fetch transfer accepted this cycle.
- fetch_rvalid_o  out  1  fetch read data valid.
- fetch_rdata_o  out  8  fetch read data.
- lsu_req_i  in  1  LSU requests an access.
- lsu_we_i  in  1  1 = write, 0 = read.
- lsu_lock_i  in  1  keep the port for the LSU (read-modify-write).
- lsu_addr_i  in  MEM_ADDR_SIZE  LSU address.
- lsu_wdata_i  in  8  LSU write data.
- lsu_gnt_o  out  1  LSU transfer accepted this cycle.
- lsu_rvalid_o  out  1  LSU read data valid.
- lsu_rdata_o  out  8  LSU read data.
- mem_req_o  out  1  memory access this cycle.
- mem_we_o  out  1  memory write enable.
- mem_addr_o  out  MEM_ADDR_SIZE  memory address.
- mem_wdata_o  out  8  memory write data.
- mem_rdata_i  in  8  read data; valid the cycle after a read is issued.

## Operation
- Handshake:
  - A transfer occurs when req and gnt are both high in the same cycle.
  - The requester holds req, addr, we and wdata stable until granted.
  - gnt is combinational from the current inputs and state.
  - The memory is always ready and never stalls.
- Grant decision, in priority order:
  1. rst high: no grant.
  2. lock_q (registered lock) high: only the LSU may be granted; fetch_gnt_o = 0 even if lsu_req_i is low.
  3. fetch_req_i high and starve_cnt == STARVE_LIMIT: grant fetch.
  4. lsu_req_i high: grant LSU.
  5. fetch_req_i high: grant fetch.
- Output muxing:
  - mem_req_o = OR of the two grants.
  - mem_addr_o, mem_we_o and mem_wdata_o come from the granted requester.
  - With no grant: mem_we_o = 0, mem_addr_o = 0, mem_wdata_o = 0.
  - A fetch is always a read (mem_we_o = 0).
- Lock:
  - lock_q is set on an LSU grant with lsu_lock_i = 1.
  - lock_q is cleared on an LSU grant with lsu_lock_i = 0, or by rst.
- Starvation counter starve_cnt (3 bits):
  - Increments, saturating at STARVE_LIMIT, on an LSU grant while fetch_req_i = 1 and lock_q = 0.
  - Clears on a fetch grant or whenever fetch_req_i = 0.
  - Holds while lock_q = 1.
- Response routing:
  - owner_q is registered each cycle:
    - OWN_FETCH on a fetch grant;
    - OWN_LSU on an LSU read grant;
    - otherwise OWN_NONE (this includes LSU writes).
  - fetch_rvalid_o = (owner_q == OWN_FETCH); lsu_rvalid_o = (owner_q == OWN_LSU).
  - Each rdata output = mem_rdata_i when its rvalid is high, else 8'h00.

## Timing
- Grant latency is 0 cycles: the same cycle as the request when arbitration is won.
- Read data latency is 1 cycle after the grant. Back-to-back reads are allowed every cycle, so one response can be in flight while the next request is granted.
- Reset values:
  - gnt, rvalid and mem_req_o are all 0; rdata, mem_addr_o and mem_wdata_o are 0.
  - owner_q = OWN_NONE, lock_q = 0, starve_cnt = 0.
  - While rst is high, grants and mem_req_o are forced to 0 combinationally.
- Reset mid-operation: a read granted in the cycle before rst rises still produces its rvalid during the rst cycle. The cycle after rst falls has no rvalid.
- Simultaneous requests with starve_cnt < STARVE_LIMIT: the LSU wins and fetch waits.
- Lock release: the LSU grant with lsu_lock_i = 0 is the last locked access. Fetch becomes eligible in the following cycle.

## Structure
- Additions to nes_cpu_pkg:
  - arb_owner_t enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_LSU};
  - STARVE_LIMIT default constant.
  - Reuse MEM_ADDR_SIZE and BYTE from the package.
- Single module; no sub-module is needed.

## Test plan
- Idle after reset: no requests → all outputs 0; fetch_req_i with addr 16'h8000 → fetch_gnt_o = 1 and mem_addr_o = 16'h8000 in the same cycle; next cycle fetch_rvalid_o = 1 with rdata equal to mem_rdata_i (e.g. 8'hEA).
- Contention: both requesting, LSU read at 16'h0200 → LSU granted; response routed only to lsu_rdata_o; fetch_rvalid_o stays 0.
- Starvation: fetch held high while LSU requests every cycle, STARVE_LIMIT = 4 → 4 LSU grants, then fetch granted on the 5th cycle, then LSU resumes.
- Lock: LSU read at 16'h0010 with lock = 1, then an idle cycle, then a write with lock = 0, fetch requesting throughout → fetch_gnt_o = 0 until the cycle after the write grant.
- LSU write of 8'h5A to 16'h0300 → mem_we_o = 1 and mem_wdata_o = 8'h5A; no rvalid the next cycle.
- Reset mid-read: fetch read granted, rst asserted the next cycle → rvalid in the rst cycle only; lock_q and starve_cnt cleared; no grants while rst is high.

Source files
------------

// File: rtl/nes_cpu_pkg.sv
// rtl/nes_cpu_pkg.sv - shared CPU constants and types
package nes_cpu_pkg;

  localparam int MEM_ADDR_SIZE = 16;
  localparam int BYTE = 8;

  // Default number of back-to-back LSU grants tolerated while fetch waits
  localparam int STARVE_LIMIT_DEF = 4;

  // Which requester owns the read response arriving this cycle
  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_LSU   = 2'd2
  } arb_owner_t;

endpackage

// File: rtl/nes_mem_arbiter.sv
// rtl/nes_mem_arbiter.sv - fetch/LSU arbiter for the single CPU memory port
module nes_mem_arbiter
  import nes_cpu_pkg::*;
#(
  parameter int MEM_ADDR_SIZE = nes_cpu_pkg::MEM_ADDR_SIZE,
  parameter int STARVE_LIMIT  = nes_cpu_pkg::STARVE_LIMIT_DEF
) (
  input  logic                     clk,
  input  logic                     rst,

  input  logic                     fetch_req_i,
  input  logic [MEM_ADDR_SIZE-1:0] fetch_addr_i,
  output logic                     fetch_gnt_o,
  output logic                     fetch_rvalid_o,
  output logic [BYTE-1:0]          fetch_rdata_o,

  input  logic                     lsu_req_i,
  input  logic                     lsu_we_i,
  input  logic                     lsu_lock_i,
  input  logic [MEM_ADDR_SIZE-1:0] lsu_addr_i,
  input  logic [BYTE-1:0]          lsu_wdata_i,
  output logic                     lsu_gnt_o,
  output logic                     lsu_rvalid_o,
  output logic [BYTE-1:0]          lsu_rdata_o,

  output logic                     mem_req_o,
  output logic                     mem_we_o,
  output logic [MEM_ADDR_SIZE-1:0] mem_addr_o,
  output logic [BYTE-1:0]          mem_wdata_o,
  input  logic [BYTE-1:0]          mem_rdata_i
);

  localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIMIT);

  logic       lock_q;
  logic [2:0] starve_cnt;
  arb_owner_t owner_q;
  logic       fetch_gnt;
  logic       lsu_gnt;

  // Grant decision: lock first, then starvation guard, then LSU priority
  always_comb begin
    fetch_gnt = 1'b0;
    lsu_gnt   = 1'b0;
    if (!rst) begin
      if (lock_q) begin
        lsu_gnt = lsu_req_i;
      end else if (fetch_req_i && (starve_cnt == STARVE_MAX)) begin
        fetch_gnt = 1'b1;
      end else if (lsu_req_i) begin
        lsu_gnt = 1'b1;
      end else if (fetch_req_i) begin
        fetch_gnt = 1'b1;
      end
    end
  end

  // Drive the memory port from whichever requester won; idle port is all zero
  always_comb begin
    mem_req_o   = fetch_gnt | lsu_gnt;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (lsu_gnt) begin
      mem_we_o    = lsu_we_i;
      mem_addr_o  = lsu_addr_i;
      mem_wdata_o = lsu_wdata_i;
    end else if (fetch_gnt) begin
      mem_addr_o  = fetch_addr_i;
    end
  end

  // Lock, starvation counter and response owner tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q     <= 1'b0;
      starve_cnt <= 3'd0;
      owner_q    <= OWN_NONE;
    end else begin
      if (lsu_gnt) begin
        lock_q <= lsu_lock_i;
      end

      // Locked sequences are atomic, so they neither count against nor relieve fetch
      if (!lock_q) begin
        if (fetch_gnt || !fetch_req_i) begin
          starve_cnt <= 3'd0;
        end else if (lsu_gnt && (starve_cnt != STARVE_MAX)) begin
          starve_cnt <= starve_cnt + 3'd1;
        end
      end

      if (fetch_gnt) begin
        owner_q <= OWN_FETCH;
      end else if (lsu_gnt && !lsu_we_i) begin
        owner_q <= OWN_LSU;
      end else begin
        owner_q <= OWN_NONE;
      end
    end
  end

  // Route the one-cycle-late read data back to its owner
  always_comb begin
    fetch_rvalid_o = (owner_q == OWN_FETCH);
    lsu_rvalid_o   = (owner_q == OWN_LSU);
    fetch_rdata_o  = fetch_rvalid_o ? mem_rdata_i : '0;
    lsu_rdata_o    = lsu_rvalid_o ? mem_rdata_i : '0;
  end

  assign fetch_gnt_o = fetch_gnt;
  assign lsu_gnt_o   = lsu_gnt;

endmodule
